// File: rtl/idp_pkg.sv
// Shared definitions for the pipelined integer datapath.
// Holds the default geometry and the 4-bit ALU opcode map.
package idp_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 8;

  localparam logic [3:0] OP_PASS_R = 4'd0;
  localparam logic [3:0] OP_PASS_S = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_INC    = 4'd4;
  localparam logic [3:0] OP_DEC    = 4'd5;
  localparam logic [3:0] OP_AND    = 4'd6;
  localparam logic [3:0] OP_OR     = 4'd7;
  localparam logic [3:0] OP_XOR    = 4'd8;
  localparam logic [3:0] OP_NOT    = 4'd9;
  localparam logic [3:0] OP_SHL    = 4'd10;
  localparam logic [3:0] OP_SHR    = 4'd11;
  localparam logic [3:0] OP_ASR    = 4'd12;
  localparam logic [3:0] OP_NEG    = 4'd13;
  localparam logic [3:0] OP_ZERO   = 4'd14;
  localparam logic [3:0] OP_ONES   = 4'd15;
endpackage

// File: rtl/idp_alu.sv
// Combinational ALU for the pipelined integer datapath.
// Ports: r_i/s_i operands, op_i opcode; res_o result, c_o carry,
// n_o negative (MSB), z_o zero.
// All add-type ops share one adder a + b + cin; subtract-type ops
// feed ~S with cin=1 so C reads as "no borrow".
module idp_alu
  import idp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] r_i,
  input  logic [DATA_W-1:0] s_i,
  input  logic [3:0]        op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              c_o,
  output logic              n_o,
  output logic              z_o
);
  logic [DATA_W-1:0] a, b;
  logic              cin;
  logic [DATA_W:0]   sum;

  always_comb begin
    a   = r_i;
    b   = s_i;
    cin = 1'b0;
    case (op_i)
      OP_SUB: begin b = ~s_i;                 cin = 1'b1; end
      OP_INC: begin b = '0;                   cin = 1'b1; end
      OP_DEC: begin b = ~DATA_W'(1);          cin = 1'b1; end
      OP_NEG: begin a = '0;  b = ~r_i;        cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};

  always_comb begin
    res_o = '0;
    c_o   = 1'b0;
    case (op_i)
      OP_PASS_R: res_o = r_i;
      OP_PASS_S: res_o = s_i;
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG:
                 {c_o, res_o} = sum;
      OP_AND:    res_o = r_i & s_i;
      OP_OR:     res_o = r_i | s_i;
      OP_XOR:    res_o = r_i ^ s_i;
      OP_NOT:    res_o = ~r_i;
      OP_SHL:    begin res_o = {r_i[DATA_W-2:0], 1'b0};        c_o = r_i[DATA_W-1]; end
      OP_SHR:    begin res_o = {1'b0, r_i[DATA_W-1:1]};        c_o = r_i[0];        end
      OP_ASR:    begin res_o = {r_i[DATA_W-1], r_i[DATA_W-1:1]}; c_o = r_i[0];      end
      OP_ZERO:   res_o = '0;
      OP_ONES:   res_o = '1;
      default:   res_o = '0;
    endcase
  end

  assign n_o = res_o[DATA_W-1];
  assign z_o = (res_o == '0);
endmodule

// File: rtl/pipelined_int_datapath.sv
// Two-stage pipelined integer datapath: register file, S-operand mux,
// ALU, registered result and C/N/Z flags.
// Ports: clk, reset (sync, active-high); issue side In_Valid, Stall,
// W_En, W_Adr, R_Adr, S_Adr, DS, S_Sel, Alu_Op; completion side
// Out_Valid, Reg_Out, Alu_Out, C, N, Z.
// Stage 1 latches operands at issue; stage 2 executes and, at its end,
// registers the outputs and writes the file. Operands read at issue are
// forwarded from the stage-2 ALU result so back-to-back ops never stall.
// Build option: IDP_R0_ZERO_EN hardwires register 0 to zero.
module pipelined_int_datapath
  import idp_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              In_Valid,
  input  logic              Stall,
  input  logic              W_En,
  input  logic [AW-1:0]     W_Adr,
  input  logic [AW-1:0]     R_Adr,
  input  logic [AW-1:0]     S_Adr,
  input  logic [DATA_W-1:0] DS,
  input  logic              S_Sel,
  input  logic [3:0]        Alu_Op,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Reg_Out,
  output logic [DATA_W-1:0] Alu_Out,
  output logic              C,
  output logic              N,
  output logic              Z
);
`ifdef IDP_R0_ZERO_EN
  localparam logic R0_ZERO = 1'b1;
`else
  localparam logic R0_ZERO = 1'b0;
`endif

  logic [NREGS-1:0][DATA_W-1:0] rf_q;
  // vld_pipe_q[1]: stage 2 holds an op; vld_pipe_q[2]: outputs valid
  logic [2:1]        vld_pipe_q;
  logic [DATA_W-1:0] r_q, s_q, r_d, s_d;
  logic [3:0]        op_q;
  logic              we_q;
  logic [AW-1:0]     wa_q;
  logic [DATA_W-1:0] alu_q, rout_q, file_r, file_s, alu_res;
  logic              c_q, n_q, z_q, alu_c, alu_n, alu_z;
  logic              wr_ok;

  idp_alu #(.DATA_W(DATA_W)) u_alu (
    .r_i(r_q), .s_i(s_q), .op_i(op_q),
    .res_o(alu_res), .c_o(alu_c), .n_o(alu_n), .z_o(alu_z)
  );

  // Stage 2 will write the file; a dropped R0 write must not forward either.
  assign wr_ok  = vld_pipe_q[1] & we_q & ~(R0_ZERO & (wa_q == '0));

  assign file_r = (R0_ZERO && R_Adr == '0) ? '0 : rf_q[R_Adr];
  assign file_s = (R0_ZERO && S_Adr == '0) ? '0 : rf_q[S_Adr];

  always_comb begin
    r_d = (wr_ok && wa_q == R_Adr) ? alu_res : file_r;
    if (S_Sel)                      s_d = DS;
    else if (wr_ok && wa_q == S_Adr) s_d = alu_res;
    else                            s_d = file_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q       <= '0;
      vld_pipe_q <= '0;
      r_q        <= '0;
      s_q        <= '0;
      op_q       <= '0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      alu_q      <= '0;
      rout_q     <= '0;
      c_q        <= 1'b0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
    end else if (!Stall) begin
      vld_pipe_q <= {vld_pipe_q[1], In_Valid};
      if (In_Valid) begin
        r_q  <= r_d;
        s_q  <= s_d;
        op_q <= Alu_Op;
        we_q <= W_En;
        wa_q <= W_Adr;
      end
      // Bubbles leave the last result and flags in place.
      if (vld_pipe_q[1]) begin
        alu_q  <= alu_res;
        rout_q <= r_q;
        c_q    <= alu_c;
        n_q    <= alu_n;
        z_q    <= alu_z;
      end
      if (wr_ok) rf_q[wa_q] <= alu_res;
    end
  end

  assign Out_Valid = vld_pipe_q[2];
  assign Alu_Out   = alu_q;
  assign Reg_Out   = rout_q;
  assign C         = c_q;
  assign N         = n_q;
  assign Z         = z_q;
endmodule

// File: tb/tb_pipelined_int_datapath.sv
module tb_pipelined_int_datapath;
  import idp_pkg::*;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = $clog2(NR);
`ifdef IDP_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clk = 1'b0, reset, In_Valid, Stall, W_En, S_Sel;
  logic [AW-1:0] W_Adr, R_Adr, S_Adr;
  logic [DW-1:0] DS, Reg_Out, Alu_Out;
  logic [3:0] Alu_Op;
  logic Out_Valid, C, N, Z;

  pipelined_int_datapath #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .reset(reset), .In_Valid(In_Valid), .Stall(Stall), .W_En(W_En),
    .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .DS(DS), .S_Sel(S_Sel),
    .Alu_Op(Alu_Op), .Out_Valid(Out_Valid), .Reg_Out(Reg_Out), .Alu_Out(Alu_Out),
    .C(C), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cycle = 0;

  // ---------------- reference model (sequential ISA semantics) ----------
  typedef struct packed {
    logic [DW-1:0] res;
    logic [DW-1:0] rout;
    logic c, n, z;
  } res_t;

  logic [DW-1:0] mregs [NR];
  logic slot_v, out_v;
  res_t slot, outr;

  function automatic res_t model_op(logic [3:0] op, logic [DW-1:0] r, logic [DW-1:0] s);
    res_t o;
    logic [DW-1:0] y;
    logic [DW:0] t;
    logic c;
    y = '0; c = 1'b0;
    case (op)
      OP_PASS_R: y = r;
      OP_PASS_S: y = s;
      OP_ADD:    begin t = {1'b0, r} + {1'b0, s}; y = t[DW-1:0]; c = t[DW]; end
      OP_SUB:    begin y = r - s; c = (r >= s); end
      OP_INC:    begin y = r + 1'b1; c = (r == {DW{1'b1}}); end
      OP_DEC:    begin y = r - 1'b1; c = (r != 0); end
      OP_AND:    y = r & s;
      OP_OR:     y = r | s;
      OP_XOR:    y = r ^ s;
      OP_NOT:    y = ~r;
      OP_SHL:    begin y = r << 1; c = r[DW-1]; end
      OP_SHR:    begin y = r >> 1; c = r[0]; end
      OP_ASR:    begin y = $signed(r) >>> 1; c = r[0]; end
      OP_NEG:    begin y = -r; c = (r == 0); end
      OP_ZERO:   y = '0;
      default:   y = '1;
    endcase
    o.res = y; o.rout = r; o.c = c; o.n = y[DW-1]; o.z = (y == 0);
    return o;
  endfunction

  function automatic logic [DW-1:0] rd(logic [AW-1:0] a);
    return (R0Z && a == 0) ? '0 : mregs[a];
  endfunction

  // ---------------- one clock cycle: drive, edge, model, check ---------
  task automatic cyc(input logic rst, input logic iv, input logic st, input logic [3:0] op,
                     input logic [AW-1:0] ra, input logic [AW-1:0] sa, input logic ss,
                     input logic [DW-1:0] ds, input logic we, input logic [AW-1:0] wa);
    logic [DW-1:0] r, s;
    reset = rst; In_Valid = iv; Stall = st; Alu_Op = op; R_Adr = ra; S_Adr = sa;
    S_Sel = ss; DS = ds; W_En = we; W_Adr = wa;
    @(posedge clk);
    cycle++;
    if (rst) begin
      for (int i = 0; i < NR; i++) mregs[i] = '0;
      slot_v = 1'b0; out_v = 1'b0; outr = '0;
    end else if (!st) begin
      if (slot_v) outr = slot;
      out_v = slot_v;
      slot_v = iv;
      if (iv) begin
        r = rd(ra);
        s = ss ? ds : rd(sa);
        slot = model_op(op, r, s);
        if (we && !(R0Z && wa == 0)) mregs[wa] = slot.res;
      end
    end
    #1;
    tests++;
    if (Out_Valid !== out_v || Alu_Out !== outr.res || Reg_Out !== outr.rout ||
        C !== outr.c || N !== outr.n || Z !== outr.z) begin
      fails++;
      $display("FAIL model cycle %0d: got vld=%0b alu=%h rout=%h cnz=%b%b%b, want vld=%0b alu=%h rout=%h cnz=%b%b%b",
               cycle, Out_Valid, Alu_Out, Reg_Out, C, N, Z, out_v, outr.res, outr.rout, outr.c, outr.n, outr.z);
    end
  endtask

  task automatic bubble();
    cyc(1'b0, 1'b0, 1'b0, OP_ZERO, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table -----------------------------
  typedef struct {
    logic [3:0] op;
    logic [AW-1:0] ra, sa, wa;
    logic we, ss;
    logic [DW-1:0] ds, e_res;
    logic e_c, e_n, e_z;
  } vec_t;
  vec_t tab[$];

  function automatic vec_t mk(logic [3:0] op, int ra, int sa, bit ss, logic [DW-1:0] ds, bit we, int wa,
                              logic [DW-1:0] er, bit ec, bit en, bit ez);
    vec_t v;
    v.op = op; v.ra = AW'(ra); v.sa = AW'(sa); v.ss = ss; v.ds = ds; v.we = we; v.wa = AW'(wa);
    v.e_res = er; v.e_c = ec; v.e_n = en; v.e_z = ez;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] ALL;
    ALL = '1;
    slot_v = 0; out_v = 0; outr = '0; slot = '0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;

    //                 op         ra sa ss ds         we wa  result           c  n  z
    tab.push_back(mk(OP_PASS_S, 0, 0, 1, DW'(5),    1, 1, DW'(5),          0, 0, 0));
    tab.push_back(mk(OP_ADD,    1, 0, 1, DW'(3),    1, 2, DW'(8),          0, 0, 0));
    tab.push_back(mk(OP_ADD,    2, 1, 0, '0,        1, 5, DW'(13),         0, 0, 0));
    tab.push_back(mk(OP_PASS_S, 0, 0, 1, ALL,       1, 3, ALL,             0, 1, 0));
    tab.push_back(mk(OP_ADD,    3, 0, 1, DW'(1),    0, 0, '0,              1, 0, 1));
    tab.push_back(mk(OP_PASS_S, 0, 0, 1, DW'(3),    1, 6, DW'(3),          0, 0, 0));
    tab.push_back(mk(OP_SUB,    6, 0, 1, DW'(5),    0, 0, ALL - 1'b1,      0, 1, 0));
    tab.push_back(mk(OP_PASS_S, 0, 0, 1, DW'(1),    1, 7, DW'(1),          0, 0, 0));
    tab.push_back(mk(OP_SHR,    7, 0, 0, '0,        0, 0, '0,              1, 0, 1));
    tab.push_back(mk(OP_PASS_S, 0, 0, 1, DW'(7),    1, 0, DW'(7),          0, 0, 0));
    tab.push_back(mk(OP_PASS_R, 0, 0, 0, '0,        0, 0, R0Z ? '0 : DW'(7), 0, 0, R0Z));
    tab.push_back(mk(OP_DEC,    6, 0, 0, '0,        0, 0, DW'(2),          1, 0, 0));
    tab.push_back(mk(OP_NEG,    7, 0, 0, '0,        0, 0, ALL,             0, 1, 0));
    tab.push_back(mk(OP_ASR,    3, 0, 0, '0,        0, 0, ALL,             1, 1, 0));
    tab.push_back(mk(OP_SHL,    3, 0, 0, '0,        0, 0, ALL - 1'b1,      1, 1, 0));
    tab.push_back(mk(OP_XOR,    1, 2, 0, '0,        0, 0, DW'(13),         0, 0, 0));
    tab.push_back(mk(OP_INC,    3, 0, 0, '0,        0, 0, '0,              1, 0, 1));
    tab.push_back(mk(OP_ONES,   0, 0, 0, '0,        0, 0, ALL,             0, 1, 0));
    tab.push_back(mk(OP_ZERO,   0, 0, 0, '0,        0, 0, '0,              0, 0, 1));

    // reset state
    cyc(1'b1, 1'b1, 1'b0, OP_ONES, '0, '0, 1'b1, ALL, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, OP_ZERO, '0, '0, 1'b0, '0, 1'b0, '0);
    chk("reset_out_valid", 64'(Out_Valid), 64'd0);
    chk("reset_alu_out", 64'(Alu_Out), 64'd0);
    chk("reset_flags", 64'({C, N, Z}), 64'd0);

    // table: output of entry i-1 is visible after edge i
    for (int i = 0; i <= tab.size(); i++) begin
      if (i < tab.size())
        cyc(1'b0, 1'b1, 1'b0, tab[i].op, tab[i].ra, tab[i].sa, tab[i].ss, tab[i].ds, tab[i].we, tab[i].wa);
      else
        bubble();
      if (i >= 1) begin
        tests++;
        if (Out_Valid !== 1'b1 || Alu_Out !== tab[i-1].e_res ||
            {C, N, Z} !== {tab[i-1].e_c, tab[i-1].e_n, tab[i-1].e_z}) begin
          fails++;
          $display("FAIL vec%0d: got vld=%0b alu=%h cnz=%b%b%b, want vld=1 alu=%h cnz=%b%b%b",
                   i - 1, Out_Valid, Alu_Out, C, N, Z, tab[i-1].e_res, tab[i-1].e_c, tab[i-1].e_n, tab[i-1].e_z);
        end
      end
    end
    bubble();
    chk("bubble_drops_valid", 64'(Out_Valid), 64'd0);
    chk("bubble_holds_alu", 64'(Alu_Out), 64'(tab[tab.size()-1].e_res));

    // stall: ADD R1(=5)+3 then 3 stalled cycles presenting a junk write to R1
    cyc(1'b0, 1'b1, 1'b0, OP_ADD, AW'(1), '0, 1'b1, DW'(3), 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1, OP_ZERO, '0, '0, 1'b0, '0, 1'b1, AW'(1));
      chk("stall_holds_valid", 64'(Out_Valid), 64'd0);
    end
    bubble();
    chk("stall_result_valid", 64'(Out_Valid), 64'd1);
    chk("stall_result_alu", 64'(Alu_Out), 64'd8);
    cyc(1'b0, 1'b1, 1'b0, OP_PASS_R, AW'(1), '0, 1'b0, '0, 1'b0, '0);
    bubble();
    chk("stall_ignored_issue", 64'(Alu_Out), 64'd5);

    // reset mid-flight: R4 write discarded
    cyc(1'b0, 1'b1, 1'b0, OP_PASS_S, '0, '0, 1'b1, DW'('h1234), 1'b1, AW'(4));
    cyc(1'b1, 1'b0, 1'b0, OP_ZERO, '0, '0, 1'b0, '0, 1'b0, '0);
    chk("midreset_valid", 64'(Out_Valid), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, OP_PASS_R, AW'(4), '0, 1'b0, '0, 1'b0, '0);
    bubble();
    chk("midreset_r4", 64'(Alu_Out), 64'd0);
    chk("midreset_r4_z", 64'(Z), 64'd1);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [31:0] rr;
      rr = $urandom;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0),
          4'($urandom), AW'($urandom), AW'($urandom), rr[0],
          (rr[1] ? DW'($urandom) : (rr[2] ? ALL : DW'(rr[5:3]))), ($urandom_range(0, 3) != 0), AW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
